// File: rtl/pkt_ingress_checker.sv
// Ingress checker: counts beats per packet, flags runt/oversize/upstream-error packets and
// emits {ERR,EOP,payload} words so the downstream commit/drop FIFO keeps or flushes them.
module pkt_ingress_checker #(
  parameter int D_WIDTH = 6,
  parameter int MIN_LEN = 2,
  parameter int MAX_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic [D_WIDTH-3:0] s_tdata,
  input  logic               s_tlast,
  input  logic               s_tuser,
  input  logic               fifo_afull,
  output logic               push,
  output logic [D_WIDTH-1:0] up_data,
  output logic [CNT_W-1:0]   pkt_ok_cnt,
  output logic [CNT_W-1:0]   pkt_drop_cnt,
  output logic               err_runt,
  output logic               err_oversize
);

  localparam logic [0:0] PASS    = 1'b0;
  localparam logic [0:0] DISCARD = 1'b1;

  // Wide enough to hold MAX_LEN+1 so the oversize beat is distinguishable.
  localparam int NW = $clog2(MAX_LEN + 2);
  localparam logic [NW-1:0] MIN_N = NW'(MIN_LEN);
  localparam logic [NW-1:0] MAX_N = NW'(MAX_LEN);

  localparam logic [D_WIDTH-1:0] DROP_WORD = {2'b11, {(D_WIDTH-2){1'b0}}};

  logic [0:0]    state;
  logic [NW-1:0] n;
  logic [NW-1:0] n_inc;
  logic          accept;
  logic          runt;

  always_comb begin
    s_tready = (state == DISCARD) ? 1'b1 : ~fifo_afull;
    accept   = s_tvalid & s_tready;
    n_inc    = n + 1'b1;
    runt     = (n_inc < MIN_N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PASS;
      n            <= '0;
      push         <= 1'b0;
      up_data      <= '0;
      pkt_ok_cnt   <= '0;
      pkt_drop_cnt <= '0;
      err_runt     <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      push         <= 1'b0;
      err_runt     <= 1'b0;
      err_oversize <= 1'b0;
      if (accept) begin
        if (state == PASS) begin
          if (n == MAX_N) begin
            // The beat past MAX_LEN is replaced by the drop marker; the rest is discarded.
            push         <= 1'b1;
            up_data      <= DROP_WORD;
            err_oversize <= 1'b1;
            n            <= '0;
            if (pkt_drop_cnt != '1) pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
            if (!s_tlast) state <= DISCARD;
          end else if (!s_tlast) begin
            push    <= 1'b1;
            up_data <= {2'b00, s_tdata};
            n       <= n_inc;
          end else if (s_tuser || runt) begin
            push     <= 1'b1;
            up_data  <= DROP_WORD;
            err_runt <= runt;
            n        <= '0;
            if (pkt_drop_cnt != '1) pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
          end else begin
            push    <= 1'b1;
            up_data <= {2'b01, s_tdata};
            n       <= '0;
            if (pkt_ok_cnt != '1) pkt_ok_cnt <= pkt_ok_cnt + 1'b1;
          end
        end else if (s_tlast) begin
          state <= PASS;
          n     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pkt_ingress_checker.sv
// Directed bench for pkt_ingress_checker (D_WIDTH=6, MIN_LEN=2, MAX_LEN=4, CNT_W=3).
module tb_pkt_ingress_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_tvalid;
  logic       s_tready;
  logic [3:0] s_tdata;
  logic       s_tlast;
  logic       s_tuser;
  logic       fifo_afull;
  logic       push;
  logic [5:0] up_data;
  logic [2:0] pkt_ok_cnt;
  logic [2:0] pkt_drop_cnt;
  logic       err_runt;
  logic       err_oversize;

  int total = 0;
  int bad   = 0;

  pkt_ingress_checker #(.D_WIDTH(6), .MIN_LEN(2), .MAX_LEN(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .s_tuser(s_tuser), .fifo_afull(fifo_afull),
    .push(push), .up_data(up_data),
    .pkt_ok_cnt(pkt_ok_cnt), .pkt_drop_cnt(pkt_drop_cnt),
    .err_runt(err_runt), .err_oversize(err_oversize)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic l, input logic u);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
  endtask

  task automatic out(input string tag, input logic p, input logic [5:0] d,
                     input logic r, input logic o);
    chk({tag, "_push"}, 32'(push), 32'(p));
    if (p) chk({tag, "_data"}, 32'(up_data), 32'(d));
    chk({tag, "_runt"}, 32'(err_runt), 32'(r));
    chk({tag, "_ovs"}, 32'(err_oversize), 32'(o));
  endtask

  task automatic cnts(input string tag, input logic [2:0] ok, input logic [2:0] drop);
    chk({tag, "_ok"}, 32'(pkt_ok_cnt), 32'(ok));
    chk({tag, "_drop"}, 32'(pkt_drop_cnt), 32'(drop));
  endtask

  initial begin
    rst = 1'b1;
    fifo_afull = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_data", 32'(up_data), 32'd0);
    chk("rst_runt", 32'(err_runt), 32'd0);
    chk("rst_ovs", 32'(err_oversize), 32'd0);
    cnts("rst", 3'd0, 3'd0);
    chk("rst_ready", 32'(s_tready), 32'd1);
    rst = 1'b0;
    step();

    // Good 3-beat packet
    drive(1'b1, 4'h1, 1'b0, 1'b0); step(); out("p3_b1", 1'b1, 6'h01, 1'b0, 1'b0);
    drive(1'b1, 4'h2, 1'b0, 1'b0); step(); out("p3_b2", 1'b1, 6'h02, 1'b0, 1'b0);
    drive(1'b1, 4'h3, 1'b1, 1'b0); step(); out("p3_b3", 1'b1, 6'h13, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0); step(); out("p3_idle", 1'b0, 6'h00, 1'b0, 1'b0);
    cnts("p3", 3'd1, 3'd0);

    // Runt 1-beat packet
    drive(1'b1, 4'h5, 1'b1, 1'b0); step(); out("runt", 1'b1, 6'h30, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0); step(); out("runt_idle", 1'b0, 6'h00, 1'b0, 1'b0);
    cnts("runt", 3'd1, 3'd1);

    // Oversize 6-beat packet; tail swallowed in DISCARD even with fifo_afull high
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b0); step();
      out("ovs_b", 1'b1, 6'(i), 1'b0, 1'b0);
    end
    drive(1'b1, 4'h5, 1'b0, 1'b0); step(); out("ovs_b5", 1'b1, 6'h30, 1'b0, 1'b1);
    fifo_afull = 1'b1;
    drive(1'b1, 4'h6, 1'b1, 1'b0);
    #1 chk("disc_ready", 32'(s_tready), 32'd1);
    step(); out("ovs_b6", 1'b0, 6'h00, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    #1 chk("pass_afull_ready", 32'(s_tready), 32'd0);
    fifo_afull = 1'b0;
    step(); cnts("ovs", 3'd1, 3'd2);

    // Exactly MAX_LEN beats commits
    drive(1'b1, 4'h7, 1'b0, 1'b0); step(); out("max_b1", 1'b1, 6'h07, 1'b0, 1'b0);
    drive(1'b1, 4'h8, 1'b0, 1'b0); step(); out("max_b2", 1'b1, 6'h08, 1'b0, 1'b0);
    drive(1'b1, 4'h9, 1'b0, 1'b0); step(); out("max_b3", 1'b1, 6'h09, 1'b0, 1'b0);
    drive(1'b1, 4'hA, 1'b1, 1'b0); step(); out("max_b4", 1'b1, 6'h1A, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0); step(); cnts("max", 3'd2, 3'd2);

    // Upstream error on last beat of a 2-beat packet
    drive(1'b1, 4'hA, 1'b0, 1'b0); step(); out("usr_b1", 1'b1, 6'h0A, 1'b0, 1'b0);
    drive(1'b1, 4'hB, 1'b1, 1'b1); step(); out("usr_b2", 1'b1, 6'h30, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0); step(); cnts("usr", 3'd2, 3'd3);

    // Runt with upstream error counts once and still flags runt
    drive(1'b1, 4'hC, 1'b1, 1'b1); step(); out("runtusr", 1'b1, 6'h30, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0); step(); cnts("runtusr", 3'd2, 3'd4);

    // fifo_afull stall mid-packet; stalled inputs must be ignored
    drive(1'b1, 4'h1, 1'b0, 1'b0); step(); out("stl_b1", 1'b1, 6'h01, 1'b0, 1'b0);
    fifo_afull = 1'b1;
    drive(1'b1, 4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stl_ready", 32'(s_tready), 32'd0);
      step(); out("stl_hold", 1'b0, 6'h00, 1'b0, 1'b0);
    end
    fifo_afull = 1'b0;
    drive(1'b1, 4'h2, 1'b0, 1'b0); step(); out("stl_b2", 1'b1, 6'h02, 1'b0, 1'b0);
    drive(1'b1, 4'h3, 1'b1, 1'b0); step(); out("stl_b3", 1'b1, 6'h13, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0); step(); cnts("stl", 3'd3, 3'd4);

    // Reset mid-packet after 3 beats; a following 2-beat packet must commit
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b0); step();
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    rst = 1'b1; step();
    chk("mrst_push", 32'(push), 32'd0);
    cnts("mrst", 3'd0, 3'd0);
    rst = 1'b0;
    drive(1'b1, 4'h4, 1'b0, 1'b0); step(); out("mrst_b1", 1'b1, 6'h04, 1'b0, 1'b0);
    drive(1'b1, 4'h5, 1'b1, 1'b0); step(); out("mrst_b2", 1'b1, 6'h15, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0); step(); cnts("mrst", 3'd1, 3'd0);

    // Counter saturation at 7
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 4'h1, 1'b1, 1'b0); step();
    end
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 4'h1, 1'b0, 1'b0); step();
      drive(1'b1, 4'h2, 1'b1, 1'b0); step();
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0); step();
    cnts("sat", 3'd7, 3'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
